// File: rtl/line_monitor.sv
// Wired-line monitor: synchronizes and deglitches an open-drain style line,
// flags edges, and hands the duration of each settled level to a consumer.
module line_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned WIDTH         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             line_in,
  input  logic             overflow_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [WIDTH-1:0] width_data,
  output logic             width_level,
  output logic             width_valid,
  input  logic             width_ready,
  output logic             overflow
);

  localparam logic [7:0]       STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IVAL_MAX    = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == IVAL_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + WIDTH'(1);
    end
  endfunction

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       stab_q, stab_d;
  logic [WIDTH-1:0] ival_q, ival_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wlevel_q, wlevel_d;
  logic             wvalid_q, wvalid_d;
  logic             ovf_q, ovf_d;
  logic             toggle_s;
  logic             load_s;
  logic             drop_s;

  // Next-state logic: filter, edge pulses, interval counter, capture handshake.
  always_comb begin
    sync1_d  = line_in;
    sync2_d  = sync1_q;
    toggle_s = 1'b0;
    stab_d   = 8'd0;

    if (sync2_q != level_q) begin
      if (stab_q == STABLE_LAST) begin
        toggle_s = 1'b1;
        stab_d   = 8'd0;
      end else begin
        toggle_s = 1'b0;
        stab_d   = stab_q + 8'd1;
      end
    end else begin
      toggle_s = 1'b0;
      stab_d   = 8'd0;
    end

    level_d = toggle_s ? ~level_q : level_q;
    rise_d  = toggle_s & ~level_q;
    fall_d  = toggle_s & level_q;
    // The toggle cycle itself is the first cycle of the new level.
    ival_d  = toggle_s ? WIDTH'(1) : sat_inc(ival_q);

    load_s   = toggle_s & (~wvalid_q | width_ready);
    drop_s   = toggle_s & wvalid_q & ~width_ready;
    wdata_d  = wdata_q;
    wlevel_d = wlevel_q;
    wvalid_d = wvalid_q;

    if (load_s) begin
      wdata_d  = ival_q;
      wlevel_d = level_q;
      wvalid_d = 1'b1;
    end else if (wvalid_q && width_ready) begin
      wvalid_d = 1'b0;
    end else begin
      wvalid_d = wvalid_q;
    end

    // A drop in the same cycle as a clear must not be lost.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset models an idle pulled-high line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      level_q  <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stab_q   <= 8'd0;
      ival_q   <= '0;
      wdata_q  <= '0;
      wlevel_q <= 1'b0;
      wvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stab_q   <= stab_d;
      ival_q   <= ival_d;
      wdata_q  <= wdata_d;
      wlevel_q <= wlevel_d;
      wvalid_q <= wvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign width_data  = wdata_q;
  assign width_level = wlevel_q;
  assign width_valid = wvalid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_line_monitor.sv
// Directed bench for line_monitor: default instance plus a WIDTH=4 instance
// for saturation; expected values are hand-computed edge counts.
module tb_line_monitor;

  logic        clock;
  logic        reset_n;
  logic        line_in, overflow_clr, width_ready;
  logic        level, rise, fall, width_level, width_valid, overflow;
  logic [15:0] width_data;

  logic        line_in4, ready4;
  logic        level4, rise4, fall4, width_level4, width_valid4, overflow4;
  logic [3:0]  width_data4;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int both_cnt = 0;

  line_monitor u_dut (
    .clock(clock), .reset_n(reset_n), .line_in(line_in), .overflow_clr(overflow_clr),
    .level(level), .rise(rise), .fall(fall), .width_data(width_data),
    .width_level(width_level), .width_valid(width_valid), .width_ready(width_ready),
    .overflow(overflow)
  );

  line_monitor #(.STABLE_CYCLES(4), .WIDTH(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .line_in(line_in4), .overflow_clr(1'b0),
    .level(level4), .rise(rise4), .fall(fall4), .width_data(width_data4),
    .width_level(width_level4), .width_valid(width_valid4), .width_ready(ready4),
    .overflow(overflow4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rise && fall) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each; counts pulses.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (rise || fall) pulse_cnt++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, 32'(level), 32'd1);
    check({tag, "_rise"}, 32'(rise), 32'd0);
    check({tag, "_fall"}, 32'(fall), 32'd0);
    check({tag, "_wdata"}, 32'(width_data), 32'd0);
    check({tag, "_wlevel"}, 32'(width_level), 32'd0);
    check({tag, "_wvalid"}, 32'(width_valid), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b1;
    line_in      = 1'b1;
    overflow_clr = 1'b0;
    width_ready  = 1'b0;
    line_in4     = 1'b1;
    ready4       = 1'b1;
    #1 reset_n   = 1'b0;
    #2;
    check_reset_vals("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Idle high for 20 cycles: nothing happens (20 edges counted).
    pulse_cnt = 0;
    run(20);
    check("idle_level", 32'(level), 32'd1);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);
    check("idle_valid", 32'(width_valid), 32'd0);

    // 3-cycle low glitch is filtered out (18 more edges, 38 total).
    line_in = 1'b0;
    run(3);
    line_in = 1'b1;
    run(15);
    check("glitch_level", 32'(level), 32'd1);
    check("glitch_pulses", 32'(pulse_cnt), 32'd0);
    check("glitch_valid", 32'(width_valid), 32'd0);

    // Clean fall: level changes on the 6th edge, capture = 38 + 5 = 43.
    line_in = 1'b0;
    run(5);
    check("fall_e5_level", 32'(level), 32'd1);
    check("fall_e5_fall", 32'(fall), 32'd0);
    run(1);
    check("fall_e6_level", 32'(level), 32'd0);
    check("fall_e6_fall", 32'(fall), 32'd1);
    check("fall_e6_rise", 32'(rise), 32'd0);
    check("fall_e6_valid", 32'(width_valid), 32'd1);
    check("fall_e6_wlevel", 32'(width_level), 32'd1);
    check("fall_e6_wdata", 32'(width_data), 32'd43);

    // Second change while held: capture dropped, overflow set.
    line_in = 1'b1;
    run(1);
    check("fall_pulse_len", 32'(fall), 32'd0);
    run(5);
    check("drop_rise", 32'(rise), 32'd1);
    check("drop_level", 32'(level), 32'd1);
    check("drop_valid", 32'(width_valid), 32'd1);
    check("drop_wdata", 32'(width_data), 32'd43);
    check("drop_wlevel", 32'(width_level), 32'd1);
    check("drop_ovf", 32'(overflow), 32'd1);

    overflow_clr = 1'b1;
    run(1);
    overflow_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_wdata", 32'(width_data), 32'd43);

    width_ready = 1'b1;
    run(1);
    width_ready = 1'b0;
    check("hs_valid", 32'(width_valid), 32'd0);

    // Capture A: interval 1 (toggle) + clr + hs + 5 = 8, old level 1.
    line_in = 1'b0;
    run(6);
    check("capA_level", 32'(level), 32'd0);
    check("capA_valid", 32'(width_valid), 32'd1);
    check("capA_wdata", 32'(width_data), 32'd8);
    check("capA_wlevel", 32'(width_level), 32'd1);

    // Capture B coincides with handshake: valid stays 1, data = 1 + 5 = 6.
    line_in = 1'b1;
    run(5);
    width_ready = 1'b1;
    run(1);
    width_ready = 1'b0;
    check("capB_rise", 32'(rise), 32'd1);
    check("capB_valid", 32'(width_valid), 32'd1);
    check("capB_wdata", 32'(width_data), 32'd6);
    check("capB_wlevel", 32'(width_level), 32'd0);
    check("capB_ovf", 32'(overflow), 32'd0);

    // Drop and clear in the same cycle: drop wins.
    line_in = 1'b0;
    run(5);
    overflow_clr = 1'b1;
    run(1);
    overflow_clr = 1'b0;
    check("prio_ovf", 32'(overflow), 32'd1);
    check("prio_wdata", 32'(width_data), 32'd6);
    check("prio_level", 32'(level), 32'd0);

    // Reset mid-filter with a held capture.
    line_in = 1'b1;
    run(3);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    run(2);
    reset_n = 1'b1;
    pulse_cnt = 0;
    run(10);
    check("post_rst_pulses", 32'(pulse_cnt), 32'd0);
    check("post_rst_valid", 32'(width_valid), 32'd0);
    check("post_rst_level", 32'(level), 32'd1);

    // WIDTH=4 instance: first capture saturated, then 40 cycles low.
    line_in4 = 1'b0;
    run(6);
    check("w4_fall_level", 32'(level4), 32'd0);
    check("w4_fall_valid", 32'(width_valid4), 32'd1);
    check("w4_fall_wdata", 32'(width_data4), 32'd15);
    run(34);
    line_in4 = 1'b1;
    run(6);
    check("w4_rise", 32'(rise4), 32'd1);
    check("w4_valid", 32'(width_valid4), 32'd1);
    check("w4_wdata", 32'(width_data4), 32'd15);
    check("w4_wlevel", 32'(width_level4), 32'd0);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
